// File: rtl/word_assembler.sv
// word_assembler: packs accepted bytes MSB-first into words and emits them as memory write requests.
// Define WORD_ASSEMBLER_WRAP_EN to wrap out_ptr at DEPTH-1 instead of stopping in FULL.
module word_assembler #(
  parameter int          BYTES_PER_WORD = 8,
  parameter int          DEPTH          = 1024,
  parameter logic [7:0]  TERM_BYTE      = 8'hFF,
  localparam int         PTR_W          = $clog2(DEPTH),
  localparam int         CNT_W          = $clog2(BYTES_PER_WORD+1)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [7:0]                  in_byte,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [8*BYTES_PER_WORD-1:0] out_data,
  output logic [PTR_W-1:0]            out_ptr,
  output logic [CNT_W-1:0]            out_nbytes,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        full
);
  typedef enum logic [1:0] {IDLE, FILL, WRITE, FULL} state_t;
  state_t                      state_q;
  logic [8*BYTES_PER_WORD-1:0] word_q;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [PTR_W-1:0]            ptr_q;
  logic                        valid_q, last_q, full_q, rdy_q;
  logic                        accept, is_term, last_ptr;
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign accept   = in_valid && rdy_q;
  assign is_term  = in_byte == TERM_BYTE;
  assign last_ptr = ptr_q == PTR_W'(DEPTH-1);
  // in_ready is registered so it stays low through reset and rises on the first edge after it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      full_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else if (clear) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      full_q  <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          rdy_q <= 1'b1;
          if (accept && is_term) begin
            state_q <= WRITE;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
            rdy_q   <= 1'b0;
          end else if (accept) begin
            word_q <= {word_q[8*BYTES_PER_WORD-9:0], in_byte};
            cnt_q  <= cnt_d;
            if (cnt_d == CNT_W'(BYTES_PER_WORD)) begin
              state_q <= WRITE;
              valid_q <= 1'b1;
              rdy_q   <= 1'b0;
            end else begin
              state_q <= FILL;
            end
          end
        end
        WRITE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            word_q  <= '0;
            cnt_q   <= '0;
`ifdef WORD_ASSEMBLER_WRAP_EN
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            ptr_q   <= last_ptr ? '0 : ptr_q + PTR_W'(1);
`else
            state_q <= last_ptr ? FULL : IDLE;
            rdy_q   <= !last_ptr;
            full_q  <= last_ptr;
            ptr_q   <= last_ptr ? ptr_q : ptr_q + PTR_W'(1);
`endif
          end
        end
        default: rdy_q <= 1'b0;
      endcase
    end
  end
  assign in_ready   = rdy_q;
  assign out_valid  = valid_q;
  assign out_data   = word_q;
  assign out_ptr    = ptr_q;
  assign out_nbytes = cnt_q;
  assign out_last   = last_q;
  assign full       = full_q;
endmodule

// File: tb/tb_word_assembler.sv
// tb_word_assembler: randomized and directed stimulus against a queue-based byte/word reference model.
module tb_word_assembler;
  localparam int         B    = 8;
  localparam int         D    = 4;
  localparam logic [7:0] TERM = 8'hFF;
  logic        clk = 0, reset_n = 0, clear = 0, in_valid = 0, out_ready = 1;
  logic [7:0]  in_byte = '0;
  logic        in_ready, out_valid, out_last, full;
  logic [63:0] out_data;
  logic [1:0]  out_ptr;
  logic [3:0]  out_nbytes;
  typedef struct {logic [63:0] d; int n; bit l; int p;} exp_t;
  exp_t        q[$];
  byte unsigned part[$];
  bit          m_pend, m_rdy, m_full;
  int          m_ptr;
  int          checks = 0, errs = 0;

  word_assembler #(.BYTES_PER_WORD(B), .DEPTH(D), .TERM_BYTE(TERM)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ptr(out_ptr),
    .out_nbytes(out_nbytes), .out_last(out_last), .out_ready(out_ready), .full(full));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack();
    logic [63:0] d = '0;
    foreach (part[i]) d = (d << 8) | 64'(part[i]);
    return d;
  endfunction

  function automatic void model_reset(input bit rdy);
    q.delete();
    part.delete();
    m_pend = 0;
    m_full = 0;
    m_ptr  = 0;
    m_rdy  = rdy;
  endfunction

  function automatic void push(input bit l);
    exp_t e;
    e.d = pack();
    e.n = part.size();
    e.l = l;
    e.p = m_ptr;
    q.push_back(e);
    part.delete();
    m_pend = 1;
  endfunction

  // Monitor: compare the DUT against the model's current state, then step the model over the next edge.
  initial begin
    model_reset(0);
    forever begin
      @(negedge clk);
      if (!reset_n) model_reset(0);
      chk("out_valid", out_valid, m_pend);
      chk("in_ready", in_ready, m_rdy);
      chk("full", full, m_full);
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_word: got data %0h expected no word", out_data);
        end else begin
          chk("out_data", out_data, q[0].d);
          chk("out_nbytes", out_nbytes, q[0].n);
          chk("out_last", out_last, q[0].l);
          chk("out_ptr", out_ptr, q[0].p);
        end
      end
      if (!reset_n) begin
      end else if (clear) model_reset(1);
      else if (m_pend) begin
        if (out_ready) begin
          void'(q.pop_front());
          m_pend = 0;
          if (m_ptr == D-1) begin
`ifdef WORD_ASSEMBLER_WRAP_EN
            m_ptr = 0;
`else
            m_full = 1;
`endif
          end else m_ptr++;
          m_rdy = !m_full;
        end
      end else if (m_full) m_rdy = 0;
      else begin
        if (m_rdy && in_valid) begin
          if (in_byte == TERM) push(1);
          else begin
            part.push_back(in_byte);
            if (part.size() == B) push(0);
          end
        end
        m_rdy = !m_pend;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1;
    in_byte  = b;
    for (int i = 0; i < 50; i++) begin
      logic r;
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) break;
      if (i == 49) begin
        checks++;
        errs++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 for byte %0h", b);
      end
    end
    in_valid = 0;
  endtask

  task automatic send_word(input int n, input bit term, input bit gaps);
    for (int k = 0; k < n; k++) begin
      send(8'($urandom_range(0, 254)));
      if (gaps) repeat ($urandom_range(0, 1)) tick();
    end
    if (term) send(TERM);
  endtask

  task automatic pulse_clear();
    clear = 1;
    tick();
    clear = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_ptr"}, out_ptr, 0);
    chk({tag, "_nbytes"}, out_nbytes, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_full"}, full, 0);
    chk({tag, "_ready"}, in_ready, 0);
  endtask

  initial begin
    #1 check_zero("rst");
    tick();
    tick();
    reset_n = 1;
    tick();
    for (int k = 1; k <= 8; k++) send(8'(k));
    repeat (3) tick();
    send(8'hAA);
    send(8'hBB);
    send(TERM);
    repeat (3) tick();
    send(8'h11);
    send(TERM);
    repeat (3) tick();
    pulse_clear();
    // Hold a finished word for five cycles while a byte waits at the input
    out_ready = 0;
    send_word(8, 0, 1);
    in_valid = 1;
    in_byte  = 8'h55;
    repeat (5) tick();
    out_ready = 1;
    send(8'h55);
    send_word(7, 0, 0);
    repeat (3) tick();
    pulse_clear();
    for (int w = 0; w < 4; w++) send_word(8, 0, 1);
`ifdef WORD_ASSEMBLER_WRAP_EN
    send_word(8, 0, 0);
    repeat (3) tick();
    chk("wrap_full", full, 0);
`else
    repeat (3) tick();
    chk("full_set", full, 1);
    chk("full_ready", in_ready, 0);
    chk("full_ptr", out_ptr, D-1);
`endif
    pulse_clear();
    chk("clr_ptr", out_ptr, 0);
    chk("clr_full", full, 0);
    chk("clr_ready", in_ready, 1);
    send_word(3, 0, 0);
    #1 reset_n = 0;
    #1 check_zero("async");
    tick();
    reset_n = 1;
    tick();
    send_word(8, 0, 0);
    repeat (3) tick();
    send(TERM);
    repeat (3) tick();
    out_ready = 0;
    send_word(2, 1, 0);
    tick();
    out_ready = 1;
    clear = 1;
    tick();
    clear = 0;
    chk("clr_hs_ptr", out_ptr, 0);
    chk("clr_hs_valid", out_valid, 0);
    send_word(1, 1, 0);
    repeat (3) tick();
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_byte   = ($urandom_range(0, 7) == 0) ? TERM : 8'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      clear     = $urandom_range(0, 49) == 0;
      tick();
    end
    in_valid  = 0;
    clear     = 0;
    out_ready = 1;
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 Parameter BYTES_PER_WORD, default 8, bytes packed per output word (legal range 2..16).
REQ-002 Parameter DEPTH, default 1024, number of word addresses in the destination memory (minimum 2).
REQ-003 Parameter TERM_BYTE, default 8'hFF, terminating byte value.
REQ-004 Localparams PTR_W = $clog2(DEPTH) and CNT_W = $clog2(BYTES_PER_WORD+1), both derived.
REQ-005 Clock and reset are decided as follows: one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1 bit, the single clock, rising-edge active.
REQ-007 Port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-008 Port clear, input, 1 bit, synchronous restart.
REQ-009 Port in_valid, input, 1 bit, in_byte is valid.
REQ-010 Port in_byte, input, 8 bits, data byte.
REQ-011 Port in_ready, output, 1 bit, byte will be accepted this cycle.
REQ-012 Port out_valid, output, 1 bit, word write request.
REQ-013 Port out_data, output, 8*BYTES_PER_WORD bits, packed word.
REQ-014 Port out_ptr, output, PTR_W bits, write address.
REQ-015 Port out_nbytes, output, CNT_W bits, number of valid bytes in out_data.
REQ-016 Port out_last, output, 1 bit, word was closed by the terminator.
REQ-017 Port out_ready, input, 1 bit, memory accepts the word.
REQ-018 Port full, output, 1 bit, address space exhausted.

Function
REQ-019 A byte SHALL be accepted only when in_valid && in_ready are both high in the same cycle.
REQ-020 The FSM SHALL have the states IDLE (count=0), FILL (0<count<BYTES_PER_WORD), WRITE and FULL.
REQ-021 in_ready SHALL be 1 in IDLE and FILL, and 0 in WRITE, in FULL and during reset.
REQ-022 An accepted byte that is not the terminator SHALL be packed by shifting word <= {word, byte}: the first byte ends up most significant, and count increments.
REQ-023 Acceptance of the byte that makes count reach BYTES_PER_WORD SHALL enter WRITE on the next edge, with out_nbytes=BYTES_PER_WORD and out_last=0.
REQ-024 An accepted TERM_BYTE SHALL not be stored; it SHALL enter WRITE with out_nbytes=count and out_last=1.
- The partial word occupies the low count bytes; the upper bytes are zero.
REQ-025 A TERM_BYTE accepted with count=0 SHALL emit an empty word: out_nbytes=0, out_data=0, out_last=1.
REQ-026 Timing: out_valid SHALL rise the cycle after the completing or terminating byte is accepted.
- out_data, out_ptr, out_nbytes and out_last SHALL hold stable while out_valid=1 && out_ready=0.
REQ-027 On an out_valid && out_ready handshake, the block SHALL clear count and word, advance out_ptr, and return to IDLE. This gives one bubble cycle per word.
REQ-028 out_ptr SHALL equal the address of the pending word; it increments by exactly 1 per handshake.
REQ-029 Pointer wrap behaviour with wrap enabled:
- out_ptr=DEPTH-1 plus a handshake SHALL give out_ptr=0.
- full stays 0.
REQ-030 clear SHALL have priority over every other event, including a simultaneous handshake or byte. It SHALL:
- set state=IDLE, count=0, word=0, out_ptr=0 and full=0;
- drop any pending word.

Reset
REQ-031 reset_n=0 SHALL immediately force every output to zero and state=IDLE, independent of clk:
- out_valid, out_data, out_ptr, out_nbytes, out_last, full and in_ready are all 0.
REQ-032 in_ready SHALL be 1 on the first clk edge after reset_n rises.
REQ-033 Reset asserted in FILL or WRITE SHALL discard the partial or pending word without emitting it.

Configuration
REQ-034 The macro WORD_ASSEMBLER_WRAP_EN SHALL control pointer wrap.
- Defined: REQ-029 applies and the FULL state is unreachable.
- Undefined: a handshake at out_ptr=DEPTH-1 SHALL enter FULL, hold out_ptr=DEPTH-1, set full=1 and hold in_ready=0 until clear or reset.

Verification
REQ-035 BYTES_PER_WORD=8. Bytes 01..08 sent back-to-back with out_ready=1 -> out_data=64'h0102030405060708, nbytes=8, last=0, ptr=0. out_valid is high one cycle after byte 08.
REQ-036 Bytes AA, BB, then FF -> out_data=64'h000000000000AABB, nbytes=2, last=1. The next word is at ptr=1.
REQ-037 Word pending with out_ready=0 for 5 cycles -> outputs stable, in_ready=0, no byte lost. Handshake on cycle 6.
REQ-038 DEPTH=4, 5 full words sent. With the macro defined -> ptrs 0,1,2,3,0, full=0. Without the macro -> FULL after the 4th word, full=1, in_ready=0. Then clear=1 -> ptr=0, full=0, in_ready=1.
REQ-039 reset_n pulsed low mid-FILL (3 bytes held) -> all outputs 0 asynchronously. The next 8 bytes form one word at ptr=0.
REQ-040 FF with count=0 -> empty word, nbytes=0, last=1. clear asserted in the same cycle as a handshake -> ptr=0, no increment.
